// File: rtl/button_level_debounce_if.sv
// Button debouncer signal bundle: raw input toward the debouncer, qualified level and strobes back.
// The release strobe is named release_pulse because "release" is a reserved word in SystemVerilog.
interface button_level_debounce_if;
  logic btn_raw;
  logic level;
  logic press;
  logic release_pulse;
  logic bouncing;

  modport master (
    output btn_raw,
    input  level,
    input  press,
    input  release_pulse,
    input  bouncing
  );

  modport slave (
    input  btn_raw,
    output level,
    output press,
    output release_pulse,
    output bouncing
  );
endinterface

// File: rtl/button_level_debounce.sv
// Level debouncer for a mechanical button: two-flop synchroniser, then a four-state
// qualifier that accepts a change only after DB_CYCLES consecutive stable samples.
module button_level_debounce #(
  parameter int unsigned DB_CYCLES  = 2000000,
  parameter int unsigned CNT_W      = 24,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  button_level_debounce_if.slave btn
);

  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Flops reset to the polarity that reads as "released" after inversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[0], btn.btn_raw};
    end
  end

  assign s = sync_q[1] ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        level_d = 1'b0;
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        level_d = 1'b1;
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = IDLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE_LO;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        level_d = 1'b0;
      end
    endcase
  end

  assign btn.level         = level_q;
  assign btn.press         = press_q;
  assign btn.release_pulse = release_q;
  assign btn.bouncing      = (state_q == WAIT_HI) || (state_q == WAIT_LO);

endmodule
